// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and load/store.
// One req/ack transaction at a time; MEM has priority unless a waiting IF has lost too often.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    output logic          if_stall,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_ready,
    output logic          mem_stall,
    output logic          port_req,
    output logic          port_we,
    output logic [AW-1:0] port_addr,
    output logic [DW-1:0] port_wdata,
    input  logic [DW-1:0] port_rdata,
    input  logic          port_ack
);

    // state | meaning
    // IDLE  | no access in flight, requests sampled and arbitrated
    // BUSY  | port_req held, waiting for port_ack
    // DONE  | ready pulse to the granted requester, requests ignored
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        state_q;
    logic          grant_mem_q;
    logic          port_req_q;
    logic          port_we_q;
    logic [AW-1:0] port_addr_q;
    logic [DW-1:0] port_wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] mem_rdata_q;
    logic          if_ready_q;
    logic          mem_ready_q;
    logic [3:0]    starve_q;
    logic [3:0]    starve_d;

    logic mem_any;
    logic win_mem;

    always_comb begin
        mem_any  = mem_rd | mem_wr;
        win_mem  = mem_any & ~(if_req & (starve_q == LIMIT));
        starve_d = starve_q;
        // Only consumed on a grant, so !win_mem here means IF won.
        if (!win_mem) begin
            starve_d = '0;
        end else if (if_req && (starve_q != LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_mem_q  <= 1'b0;
            port_req_q   <= 1'b0;
            port_we_q    <= 1'b0;
            port_addr_q  <= '0;
            port_wdata_q <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            starve_q     <= '0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_req || mem_any) begin
                        grant_mem_q  <= win_mem;
                        port_req_q   <= 1'b1;
                        port_we_q    <= win_mem & mem_wr;
                        port_addr_q  <= win_mem ? mem_addr : if_addr;
                        port_wdata_q <= win_mem ? mem_wdata : '0;
                        starve_q     <= starve_d;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    if (port_ack) begin
                        port_req_q <= 1'b0;
                        if (!port_we_q) begin
                            if (grant_mem_q) begin
                                mem_rdata_q <= port_rdata;
                            end else begin
                                if_rdata_q <= port_rdata;
                            end
                        end
                        if (grant_mem_q) begin
                            mem_ready_q <= 1'b1;
                        end else begin
                            if_ready_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata   = if_rdata_q;
    assign if_ready   = if_ready_q;
    assign mem_rdata  = mem_rdata_q;
    assign mem_ready  = mem_ready_q;
    assign port_req   = port_req_q;
    assign port_we    = port_we_q;
    assign port_addr  = port_addr_q;
    assign port_wdata = port_wdata_q;

    assign if_stall  = if_req & ~if_ready_q;
    assign mem_stall = mem_any & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a memory responder on the port side plus a queue of
// expected completions that is checked whenever a ready pulse appears.
module tb_mem_port_arbiter;

    localparam int AW           = 32;
    localparam int DW           = 32;
    localparam int STARVE_LIMIT = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          if_stall;
    logic          mem_rd = 1'b0;
    logic          mem_wr = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          mem_stall;
    logic          port_req;
    logic          port_we;
    logic [AW-1:0] port_addr;
    logic [DW-1:0] port_wdata;
    logic [DW-1:0] port_rdata = '0;
    logic          port_ack = 1'b0;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_stall(mem_stall),
        .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
        .port_wdata(port_wdata), .port_rdata(port_rdata), .port_ack(port_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          is_mem;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t          exp_q[$];
    logic [AW-1:0] mem_next[$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] model_mem_rdata = '0;
    logic [DW-1:0] model_if_rdata = '0;

    bit            auto_ack = 1'b1;
    int            ack_delay = 2;
    logic          manual_ack = 1'b0;
    logic [DW-1:0] manual_rdata = '0;
    bit            scramble = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return a ^ 32'h2002004A;
    endfunction

    task automatic push_txn(input logic is_mem, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
        txn_t t;
        t.is_mem = is_mem;
        t.we     = we;
        t.addr   = addr;
        t.wdata  = we ? wdata : '0;
        if (!we) begin
            if (is_mem) model_mem_rdata = mem_data(addr);
            else        model_if_rdata  = mem_data(addr);
        end
        t.rdata = is_mem ? model_mem_rdata : model_if_rdata;
        exp_q.push_back(t);
    endtask

    // Memory responder and completion monitor, both on the falling edge.
    initial begin : responder
        txn_t          e;
        bit            active;
        int            wait_cnt;
        logic [AW-1:0] seen_addr;
        logic          seen_we;
        logic [DW-1:0] seen_wdata;
        active = 1'b0;
        wait_cnt = 0;
        seen_addr = '0;
        seen_we = 1'b0;
        seen_wdata = '0;
        forever begin
            @(negedge clock);
            if (if_ready || mem_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 64'({if_ready, mem_ready}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ready_owner", 64'({if_ready, mem_ready}), e.is_mem ? 64'd1 : 64'd2);
                    chk("port_addr", 64'(seen_addr), 64'(e.addr));
                    chk("port_we", 64'(seen_we), 64'(e.we));
                    if (e.we) chk("port_wdata", 64'(seen_wdata), 64'(e.wdata));
                    if (e.is_mem) chk("mem_rdata", 64'(mem_rdata), 64'(e.rdata));
                    else          chk("if_rdata", 64'(if_rdata), 64'(e.rdata));
                end
            end
            if (auto_ack) begin
                port_ack = 1'b0;
                if (port_req) begin
                    if (!active) begin
                        active     = 1'b1;
                        wait_cnt   = ack_delay;
                        seen_addr  = port_addr;
                        seen_we    = port_we;
                        seen_wdata = port_wdata;
                    end else begin
                        chk("port_addr_stable", 64'(port_addr), 64'(seen_addr));
                        chk("port_wdata_stable", 64'(port_wdata), 64'(seen_wdata));
                    end
                    if (wait_cnt == 0) begin
                        port_ack   = 1'b1;
                        port_rdata = mem_data(port_addr);
                        active     = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end
            end else begin
                active     = 1'b0;
                port_ack   = manual_ack;
                port_rdata = manual_rdata;
            end
        end
    end

    // Hold requests until their ready pulse; reload MEM from mem_next to keep it busy.
    task automatic run(input int budget);
        int cyc = 0;
        int stall_bad = 0;
        while ((if_req || mem_rd || mem_wr) && cyc < budget) begin
            @(posedge clock);
            #1;
            cyc++;
            if (if_req && !if_ready && !if_stall) stall_bad++;
            if (if_ready) if_req = 1'b0;
            if (mem_ready) begin
                if (mem_next.size() > 0) begin
                    mem_addr = mem_next.pop_front();
                end else begin
                    mem_rd = 1'b0;
                    mem_wr = 1'b0;
                end
            end
            if (scramble && port_req) begin
                mem_addr  = $urandom;
                mem_wdata = $urandom;
            end
        end
        chk("run_done", 64'({if_req, mem_rd, mem_wr}), 64'd0);
        chk("if_stall_hold", 64'(stall_bad), 64'd0);
        @(posedge clock);
        #1;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        int stall_n;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_port_req", 64'(port_req), 64'd0);
        chk("rst_port_we", 64'(port_we), 64'd0);
        chk("rst_port_addr", 64'(port_addr), 64'd0);
        chk("rst_rdy", 64'({if_ready, mem_ready}), 64'd0);
        chk("rst_rdata", 64'({if_rdata, mem_rdata}), 64'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single fetch: ack two cycles after port_req rises.
        ack_delay = 2;
        if_addr = 32'h40;
        if_req = 1'b1;
        push_txn(1'b0, 1'b0, 32'h40, '0);
        stall_n = 0;
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clock);
            if (if_ready) break;
            if (if_stall) stall_n++;
            cyc++;
        end
        chk("if_stall_cycles", 64'(stall_n), 64'd4);
        chk("if_latency", 64'(cyc), 64'd4);
        chk("if_stall_at_ready", 64'(if_stall), 64'd0);
        chk("fetch_data", 64'(if_rdata), 64'h2002000A);
        @(posedge clock);
        #1;
        if_req = 1'b0;
        @(posedge clock);
        #1;

        // Conflict: MEM first, then IF.
        ack_delay = 1;
        mem_addr = 32'h100;
        mem_rd = 1'b1;
        if_addr = 32'h80;
        if_req = 1'b1;
        push_txn(1'b1, 1'b0, 32'h100, '0);
        push_txn(1'b0, 1'b0, 32'h80, '0);
        run(100);

        // Store with inputs scrambled while in flight.
        ack_delay = 3;
        scramble = 1'b1;
        mem_addr = 32'h200;
        mem_wdata = 32'hDEADBEEF;
        mem_wr = 1'b1;
        push_txn(1'b1, 1'b1, 32'h200, 32'hDEADBEEF);
        run(100);
        scramble = 1'b0;
        chk("store_keeps_rdata", 64'(mem_rdata), 64'(mem_data(32'h100)));

        // Read and write together behave as a store.
        ack_delay = 0;
        mem_addr = 32'h300;
        mem_wdata = 32'h12345678;
        mem_rd = 1'b1;
        mem_wr = 1'b1;
        push_txn(1'b1, 1'b1, 32'h300, 32'h12345678);
        run(100);

        // Starvation: four MEM wins, then IF is forced through.
        ack_delay = 1;
        mem_addr = 32'h1000;
        mem_rd = 1'b1;
        mem_next = '{32'h1004, 32'h1008, 32'h100C, 32'h1010};
        if_addr = 32'h44;
        if_req = 1'b1;
        push_txn(1'b1, 1'b0, 32'h1000, '0);
        push_txn(1'b1, 1'b0, 32'h1004, '0);
        push_txn(1'b1, 1'b0, 32'h1008, '0);
        push_txn(1'b1, 1'b0, 32'h100C, '0);
        push_txn(1'b0, 1'b0, 32'h44, '0);
        push_txn(1'b1, 1'b0, 32'h1010, '0);
        run(300);

        // Counter cleared by the forced IF win, so MEM wins again.
        mem_addr = 32'h2000;
        mem_rd = 1'b1;
        if_addr = 32'h48;
        if_req = 1'b1;
        push_txn(1'b1, 1'b0, 32'h2000, '0);
        push_txn(1'b0, 1'b0, 32'h48, '0);
        run(100);

        // Stray ack while idle.
        auto_ack = 1'b0;
        manual_rdata = 32'hBAD0BAD0;
        manual_ack = 1'b1;
        @(posedge clock);
        #1;
        manual_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk("idle_ack_no_ready", 64'({if_ready, mem_ready, port_req}), 64'd0);
        end
        chk("idle_ack_mem_rdata", 64'(mem_rdata), 64'(model_mem_rdata));
        chk("idle_ack_if_rdata", 64'(if_rdata), 64'(model_if_rdata));

        // Reset in the middle of a read, then a late ack.
        mem_addr = 32'h400;
        mem_rd = 1'b1;
        cyc = 0;
        while (!port_req && cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("midrst_port_req_up", 64'(port_req), 64'd1);
        reset = 1'b1;
        mem_rd = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst_port_req_drop", 64'(port_req), 64'd0);
        reset = 1'b0;
        manual_ack = 1'b1;
        @(posedge clock);
        #1;
        manual_ack = 1'b0;
        chk("midrst_no_ready", 64'({if_ready, mem_ready, port_req}), 64'd0);
        @(posedge clock);
        #1;
        chk("midrst_no_ready2", 64'({if_ready, mem_ready, port_req}), 64'd0);
        chk("midrst_rdata", 64'({if_rdata, mem_rdata}), 64'd0);
        model_mem_rdata = '0;
        model_if_rdata = '0;

        // Back in IDLE: a normal fetch completes.
        auto_ack = 1'b1;
        ack_delay = 1;
        if_addr = 32'h50;
        if_req = 1'b1;
        push_txn(1'b0, 1'b0, 32'h50, '0);
        run(100);
        chk("post_rst_mem_rdata", 64'(mem_rdata), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
